// File: rtl/dram_responder.sv
// Avalon-MM style memory responder backed by a word-addressed on-chip array.
// Define DRAM_RESP_STALL_EN to add LFSR-driven random extra wait states.
module dram_responder #(
   parameter int unsigned DEPTH     = 4096,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int unsigned LATENCY   = 2,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        Read,
   input  logic        Write,
   input  logic [31:0] Address,
   input  logic [3:0]  ByteEnable,
   input  logic [31:0] WriteData,
   output logic        WaitRequest,
   output logic [31:0] ReadData,
   output logic        err,
   output logic [15:0] access_cnt
);
   localparam int unsigned AW  = $clog2(DEPTH);
   localparam logic [3:0]  LAT = 4'(LATENCY);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t         state_r;
   logic           op_write_r;
   logic [AW-1:0]  idx_r;
   logic           in_range_r;
   logic [3:0]     be_r;
   logic [31:0]    wd_r;
   logic [3:0]     wcnt_r;
   logic [31:0]    mem [DEPTH];

   logic           borrow_s;
   logic [31:0]    offset_s;
   logic           in_range_s;
   logic           req_s;
   logic           rd_in_range_s;
   logic [AW-1:0]  rd_idx_s;
   logic [31:0]    rd_word_s;

`ifdef DRAM_RESP_STALL_EN
   logic [15:0]    lfsr_r;
   logic [1:0]     extra_r;
`endif

   // Address decode on the live bus; the borrow bit flags addresses below the base.
   always_comb begin
      {borrow_s, offset_s} = {1'b0, Address} - {1'b0, BASE_ADDR};
      in_range_s = !borrow_s && ((offset_s >> 2) < 32'(DEPTH));
      req_s      = Read | Write;
   end

   // Read word for the DONE entry: live bus when LATENCY==0 jumps straight from IDLE.
   always_comb begin
      if (state_r == IDLE) begin
         rd_in_range_s = in_range_s;
         rd_idx_s      = offset_s[AW+1:2];
      end else begin
         rd_in_range_s = in_range_r;
         rd_idx_s      = idx_r;
      end
      rd_word_s = rd_in_range_s ? mem[rd_idx_s] : 32'hDEAD_BEEF;
   end

   assign WaitRequest = (state_r != DONE);

`ifdef DRAM_RESP_STALL_EN
   // Fibonacci LFSR, taps 16,14,13,11, free-running.
   always_ff @(posedge clock) begin
      if (reset) begin
         lfsr_r <= LFSR_SEED;
      end else begin
         lfsr_r <= {lfsr_r[14:0], lfsr_r[15] ^ lfsr_r[13] ^ lfsr_r[12] ^ lfsr_r[10]};
      end
   end
`endif

   // Access sequencer: IDLE -> WAIT (LATENCY cycles) -> DONE -> IDLE.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r    <= IDLE;
         ReadData   <= 32'h0000_0000;
         err        <= 1'b0;
         access_cnt <= 16'h0000;
         op_write_r <= 1'b0;
         idx_r      <= '0;
         in_range_r <= 1'b0;
         be_r       <= 4'h0;
         wd_r       <= 32'h0000_0000;
         wcnt_r     <= 4'h0;
`ifdef DRAM_RESP_STALL_EN
         extra_r    <= 2'd0;
`endif
      end else begin
         case (state_r)
            IDLE: begin
               if (req_s) begin
                  op_write_r <= Write;
                  idx_r      <= offset_s[AW+1:2];
                  in_range_r <= in_range_s;
                  be_r       <= ByteEnable;
                  wd_r       <= WriteData;
                  wcnt_r     <= LAT;
`ifdef DRAM_RESP_STALL_EN
                  extra_r    <= 2'd0;
`endif
                  if (!in_range_s || (Read && Write)) begin
                     err <= 1'b1;
                  end
                  if (LAT == 4'd0) begin
                     state_r <= DONE;
                     if (!Write) begin
                        ReadData <= rd_word_s;
                     end
                  end else begin
                     state_r <= WAIT;
                  end
               end
            end
            WAIT: begin
               // Dropping the request mid-wait abandons the access.
               if (!req_s) begin
                  state_r <= IDLE;
                  err     <= 1'b1;
               end else if (wcnt_r == 4'd1) begin
`ifdef DRAM_RESP_STALL_EN
                  if (lfsr_r[0] && (extra_r != 2'd3)) begin
                     extra_r <= extra_r + 2'd1;
                  end else begin
                     state_r <= DONE;
                     if (!op_write_r) begin
                        ReadData <= rd_word_s;
                     end
                  end
`else
                  state_r <= DONE;
                  if (!op_write_r) begin
                     ReadData <= rd_word_s;
                  end
`endif
               end else begin
                  wcnt_r <= wcnt_r - 4'd1;
               end
            end
            DONE: begin
               state_r    <= IDLE;
               access_cnt <= access_cnt + 16'd1;
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

   // Write commit on the DONE->IDLE edge; a reset in DONE discards it.
   always_ff @(posedge clock) begin
      if (!reset && (state_r == DONE) && op_write_r && in_range_r) begin
         for (int i = 0; i < 4; i++) begin
            if (be_r[i]) begin
               mem[idx_r][8*i +: 8] <= wd_r[8*i +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_dram_responder.sv
// Bench for dram_responder: directed vector table, multi-cycle corner sequences,
// and random accesses checked against a word-map scoreboard.
module tb_dram_responder;
   localparam int          LAT   = 2;
   localparam int unsigned DEPTH = 4096;
   localparam logic [31:0] BASE  = 32'h0000_0000;
`ifdef DRAM_RESP_STALL_EN
   localparam int MAX_EXTRA = 3;
`else
   localparam int MAX_EXTRA = 0;
`endif

   logic        clock;
   logic        reset;
   logic        Read;
   logic        Write;
   logic [31:0] Address;
   logic [3:0]  ByteEnable;
   logic [31:0] WriteData;
   logic        WaitRequest;
   logic [31:0] ReadData;
   logic        err;
   logic [15:0] access_cnt;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic        rd;
      logic        wr;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wd;
      logic [31:0] exp_rd;
      logic        exp_err;
      logic [15:0] exp_cnt;
   } vec_t;

   vec_t vt [13];

   logic [31:0] mdl [int unsigned];
   logic        exp_err;
   logic [15:0] exp_cnt;

   dram_responder #(
      .DEPTH(DEPTH), .BASE_ADDR(BASE), .LATENCY(LAT), .LFSR_SEED(16'hACE1)
   ) dut (
      .clock(clock), .reset(reset), .Read(Read), .Write(Write),
      .Address(Address), .ByteEnable(ByteEnable), .WriteData(WriteData),
      .WaitRequest(WaitRequest), .ReadData(ReadData), .err(err), .access_cnt(access_cnt)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_rng(input string name, input int act, input int lo, input int hi);
      n_cmp++;
      if (act < lo || act > hi) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
      end
   endtask

   task automatic do_reset();
      Read = 1'b0;
      Write = 1'b0;
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      @(posedge clock); #1;
   endtask

   // Issues one request from IDLE; lat counts edges from the sampling edge to the DONE cycle.
   task automatic do_access(input logic rd, input logic wr, input logic [31:0] a,
                            input logic [3:0] be, input logic [31:0] wd,
                            output int lat, output logic [31:0] rdata);
      lat = 0;
      rdata = 32'h0;
      check("wait_high_idle", {31'd0, WaitRequest}, 32'd1);
      Read = rd;
      Write = wr;
      Address = a;
      ByteEnable = be;
      WriteData = wd;
      for (int n = 1; n <= 40 && lat == 0; n++) begin
         @(posedge clock); #1;
         if (WaitRequest === 1'b0) begin
            lat = n;
            rdata = ReadData;
         end
      end
      Read = 1'b0;
      Write = 1'b0;
      if (lat == 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL access_timeout: no completion for addr %h within 40 cycles", a);
      end
      @(posedge clock); #1;
   endtask

   // Access checked against the scoreboard built from the address-map and byte-lane rules.
   task automatic model_access(input logic rd, input logic wr, input logic [31:0] a,
                               input logic [3:0] be, input logic [31:0] wd);
      int          lat;
      logic [31:0] rdata;
      logic [31:0] word;
      int unsigned idx;
      logic        inr;
      inr = (a >= BASE) && (((a - BASE) / 4) < DEPTH);
      idx = (a - BASE) / 4;
      do_access(rd, wr, a, be, wd, lat, rdata);
      exp_cnt = exp_cnt + 16'd1;
      if (!inr || (rd && wr)) exp_err = 1'b1;
      if (wr) begin
         if (inr) begin
            word = mdl.exists(idx) ? mdl[idx] : 32'h0;
            for (int i = 0; i < 4; i++) begin
               if (be[i]) word[8*i +: 8] = wd[8*i +: 8];
            end
            mdl[idx] = word;
         end
      end else begin
         if (!inr) check("rand_oor_data", rdata, 32'hDEAD_BEEF);
         else if (mdl.exists(idx)) check("rand_read_data", rdata, mdl[idx]);
      end
      check_rng("rand_latency", lat, LAT + 1, LAT + 1 + MAX_EXTRA);
      check("rand_err", {31'd0, err}, {31'd0, exp_err});
      check("rand_cnt", {16'd0, access_cnt}, {16'd0, exp_cnt});
   endtask

   initial begin
      int          lat;
      int          lows;
      int          dones [$];
      logic [31:0] rdata;
      logic [31:0] a;
      int          r;

      vt[0]  = '{1'b0, 1'b1, 32'h0000_0010, 4'hF, 32'h1122_3344, 32'h0,         1'b0, 16'd1};
      vt[1]  = '{1'b1, 1'b0, 32'h0000_0010, 4'h0, 32'h0,         32'h1122_3344, 1'b0, 16'd2};
      vt[2]  = '{1'b0, 1'b1, 32'h0000_0010, 4'h5, 32'hAABB_CCDD, 32'h0,         1'b0, 16'd3};
      vt[3]  = '{1'b1, 1'b0, 32'h0000_0010, 4'h0, 32'h0,         32'h11BB_33DD, 1'b0, 16'd4};
      vt[4]  = '{1'b0, 1'b1, 32'h0000_0000, 4'hF, 32'h0102_0304, 32'h0,         1'b0, 16'd5};
      vt[5]  = '{1'b1, 1'b0, 32'h0000_4000, 4'h0, 32'h0,         32'hDEAD_BEEF, 1'b1, 16'd6};
      vt[6]  = '{1'b0, 1'b1, 32'h0000_4000, 4'hF, 32'hFFFF_FFFF, 32'h0,         1'b1, 16'd7};
      vt[7]  = '{1'b1, 1'b0, 32'h0000_0000, 4'h0, 32'h0,         32'h0102_0304, 1'b1, 16'd8};
      vt[8]  = '{1'b0, 1'b1, 32'h0000_3FFC, 4'hF, 32'h5A5A_5A5A, 32'h0,         1'b1, 16'd9};
      vt[9]  = '{1'b1, 1'b0, 32'h0000_3FFF, 4'h0, 32'h0,         32'h5A5A_5A5A, 1'b1, 16'd10};
      vt[10] = '{1'b1, 1'b0, 32'hFFFF_FFFC, 4'h0, 32'h0,         32'hDEAD_BEEF, 1'b1, 16'd11};
      vt[11] = '{1'b0, 1'b1, 32'h0000_0013, 4'h8, 32'h9900_0000, 32'h0,         1'b1, 16'd12};
      vt[12] = '{1'b1, 1'b0, 32'h0000_0010, 4'h0, 32'h0,         32'h99BB_33DD, 1'b1, 16'd13};

      Read = 1'b0;
      Write = 1'b0;
      Address = 32'h0;
      ByteEnable = 4'h0;
      WriteData = 32'h0;
      reset = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      check("reset_wait", {31'd0, WaitRequest}, 32'd1);
      check("reset_rdata", ReadData, 32'h0);
      check("reset_err", {31'd0, err}, 32'd0);
      check("reset_cnt", {16'd0, access_cnt}, 32'd0);
      reset = 1'b0;
      @(posedge clock); #1;

      for (int i = 0; i < 13; i++) begin
         do_access(vt[i].rd, vt[i].wr, vt[i].addr, vt[i].be, vt[i].wd, lat, rdata);
         check_rng("vec_latency", lat, LAT + 1, LAT + 1 + MAX_EXTRA);
         if (vt[i].rd && !vt[i].wr) check("vec_rdata", rdata, vt[i].exp_rd);
         check("vec_err", {31'd0, err}, {31'd0, vt[i].exp_err});
         check("vec_cnt", {16'd0, access_cnt}, {16'd0, vt[i].exp_cnt});
      end

      // Reset while a write is waiting: write discarded, old data survives.
      do_reset();
      do_access(1'b0, 1'b1, 32'h20, 4'hF, 32'h1234_5678, lat, rdata);
      check("rst_pre_cnt", {16'd0, access_cnt}, 32'd1);
      do_reset();
      Write = 1'b1;
      Address = 32'h20;
      ByteEnable = 4'hF;
      WriteData = 32'hCAFE_F00D;
      @(posedge clock); #1;
      check("rst_in_wait", {31'd0, WaitRequest}, 32'd1);
      @(posedge clock); #1;
      reset = 1'b1;
      Write = 1'b0;
      @(posedge clock); #1;
      check("rst_mid_wait", {31'd0, WaitRequest}, 32'd1);
      check("rst_mid_rdata", ReadData, 32'h0);
      check("rst_mid_err", {31'd0, err}, 32'd0);
      check("rst_mid_cnt", {16'd0, access_cnt}, 32'd0);
      reset = 1'b0;
      @(posedge clock); #1;
      do_access(1'b1, 1'b0, 32'h20, 4'h0, 32'h0, lat, rdata);
      check("rst_old_data", rdata, 32'h1234_5678);
      check("rst_post_cnt", {16'd0, access_cnt}, 32'd1);
      check("rst_post_err", {31'd0, err}, 32'd0);

      // Abort: request dropped during WAIT.
      Read = 1'b1;
      Address = 32'h20;
      @(posedge clock); #1;
      check("abort_in_wait", {31'd0, WaitRequest}, 32'd1);
      Read = 1'b0;
      lows = 0;
      for (int n = 0; n < 6; n++) begin
         @(posedge clock); #1;
         if (WaitRequest !== 1'b1) lows++;
      end
      check("abort_no_done", lows, 0);
      check("abort_cnt", {16'd0, access_cnt}, 32'd1);
      check("abort_err", {31'd0, err}, 32'd1);

      // Read and Write together behave as a write and flag err.
      do_reset();
      do_access(1'b1, 1'b1, 32'h24, 4'hF, 32'h0000_0077, lat, rdata);
      check_rng("rw_latency", lat, LAT + 1, LAT + 1 + MAX_EXTRA);
      check("rw_err", {31'd0, err}, 32'd1);
      do_access(1'b1, 1'b0, 32'h24, 4'h0, 32'h0, lat, rdata);
      check("rw_rdata", rdata, 32'h0000_0077);
      check("rw_cnt", {16'd0, access_cnt}, 32'd2);

      // Back-to-back: held read restarts right after the IDLE cycle.
      Read = 1'b1;
      Address = 32'h10;
      for (int n = 1; n <= 40 && dones.size() < 2; n++) begin
         @(posedge clock); #1;
         if (WaitRequest === 1'b0) begin
            dones.push_back(n);
            check("b2b_rdata", ReadData, 32'h99BB_33DD);
         end
      end
      Read = 1'b0;
      @(posedge clock); #1;
      if (dones.size() == 2) begin
         check_rng("b2b_first", dones[0], LAT + 1, LAT + 1 + MAX_EXTRA);
         check_rng("b2b_gap", dones[1] - dones[0], LAT + 2, LAT + 2 + MAX_EXTRA);
      end else begin
         n_cmp++;
         n_bad++;
         $display("FAIL b2b_count: got %0d completions expected 2", dones.size());
      end
      check("b2b_cnt", {16'd0, access_cnt}, 32'd4);

      // Random accesses against the scoreboard.
      do_reset();
      exp_cnt = 16'd0;
      exp_err = 1'b0;
      for (int i = 0; i < 64; i++) begin
         model_access(1'b0, 1'b1, 32'(i * 4), 4'hF, $urandom);
      end
      for (int k = 0; k < 1000; k++) begin
         repeat ($urandom_range(0, 2)) @(posedge clock);
         #0;
         r = $urandom_range(0, 99);
         if (r < 90) a = 32'($urandom_range(0, 63) * 4) | 32'($urandom_range(0, 3));
         else if (r < 95) a = 32'h0000_4000 + 32'($urandom_range(0, 1023) * 4);
         else a = $urandom | 32'h8000_0000;
         r = $urandom_range(0, 99);
         if (r < 45) model_access(1'b1, 1'b0, a, 4'h0, 32'h0);
         else if (r < 95) model_access(1'b0, 1'b1, a, 4'($urandom_range(0, 15)), $urandom);
         else model_access(1'b1, 1'b1, a, 4'($urandom_range(0, 15)), $urandom);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
